// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//
// Top-level scheduler for the time-multiplexed MNIST classifier. One shared
// MAC unit is sequenced through layer 1 (N_PIXELS inputs x N_HIDDEN neurons)
// and then layer 2 (N_HIDDEN inputs x N_OUT neurons). The block generates
// pixel, weight and hidden-RAM read addresses, delays the MAC strobes to
// match the memory read latency, writes hidden activations back, and tracks
// the argmax of the output layer.
//
// Optional feature (compile-time macro):
//   SEQ_RELU_EN  - when defined, hidden write data is ReLU(acc_in);
//                  when undefined, hidden write data is acc_in unchanged.
//
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   start         request one inference (sampled only while idle)
//   busy          high from the cycle after an accepted start through DONE
//   pixel_addr    pixel ROM address (layer 1 term index, 0 in layer 2)
//   weight_addr   unified weight ROM address (running base + term index)
//   hid_raddr     hidden RAM read address (layer 2 term index)
//   layer         MAC operand mux select: 0 = layer 1, 1 = layer 2
//   mac_en        product valid at the MAC inputs this cycle
//   mac_first     with mac_en: load the product instead of accumulating
//   acc_in        registered MAC accumulator (signed)
//   hid_we        hidden RAM write strobe
//   hid_waddr     hidden RAM write address
//   hid_wdata     hidden RAM write data
//   digit         classified digit, held until the next DONE
//   digit_valid   one-cycle pulse accompanying a new digit
// -----------------------------------------------------------------------------
module inference_sequencer #(
  parameter int N_PIXELS = 784,
  parameter int N_HIDDEN = 10,
  parameter int N_OUT    = 10,
  parameter int MEM_LAT  = 2,
  parameter int ACC_W    = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic [9:0]              pixel_addr,
  output logic [12:0]             weight_addr,
  output logic [3:0]              hid_raddr,
  output logic                    layer,
  output logic                    mac_en,
  output logic                    mac_first,
  input  logic signed [ACC_W-1:0] acc_in,
  output logic                    hid_we,
  output logic [3:0]              hid_waddr,
  output logic signed [ACC_W-1:0] hid_wdata,
  output logic [3:0]              digit,
  output logic                    digit_valid
);

  localparam logic [9:0]  L1_LAST_TERM = 10'(N_PIXELS - 1);
  localparam logic [9:0]  L2_LAST_TERM = 10'(N_HIDDEN - 1);
  localparam logic [3:0]  L1_LAST_NEUR = 4'(N_HIDDEN - 1);
  localparam logic [3:0]  L2_LAST_NEUR = 4'(N_OUT - 1);
  localparam logic [12:0] L1_STEP      = 13'(N_PIXELS);
  localparam logic [12:0] L2_STEP      = 13'(N_HIDDEN);
  localparam logic [12:0] L2_BASE      = 13'(N_PIXELS * N_HIDDEN);
  localparam logic [7:0]  DRAIN_LAST   = 8'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  // Hidden activation function; only the hidden write path uses it.
  function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
`ifdef SEQ_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  state_t                   state_q, state_d;
  logic                     layer_q, layer_d;
  logic [3:0]               n_q, n_d;
  logic [9:0]               i_q, i_d;
  logic [7:0]               drain_q, drain_d;
  logic [12:0]              base_q, base_d;
  logic [MEM_LAT-1:0]       iss_q, iss_d;
  logic [MEM_LAT-1:0]       first_q, first_d;
  logic signed [ACC_W-1:0]  best_q, best_d;
  logic [3:0]               best_idx_q, best_idx_d;
  logic [3:0]               digit_q, digit_d;
  logic                     last_term;
  logic                     last_neur;

  always_comb begin
    last_term = layer_q ? (i_q == L2_LAST_TERM) : (i_q == L1_LAST_TERM);
    last_neur = layer_q ? (n_q == L2_LAST_NEUR) : (n_q == L1_LAST_NEUR);
  end

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    n_d         = n_q;
    i_d         = i_q;
    drain_d     = drain_q;
    base_d      = base_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    digit_d     = digit_q;
    pixel_addr  = '0;
    weight_addr = '0;
    hid_raddr   = '0;
    hid_we      = 1'b0;
    hid_waddr   = '0;
    hid_wdata   = '0;
    digit_valid = 1'b0;
    iss_d       = iss_q;
    first_d     = first_q;

    // Stage p0: issue flags enter the read-latency delay line
    iss_d[0]   = 1'b0;
    first_d[0] = 1'b0;
    for (int k = 1; k < MEM_LAT; k++) begin
      iss_d[k]   = iss_q[k-1];
      first_d[k] = first_q[k-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          layer_d = 1'b0;
          n_d     = '0;
          i_d     = '0;
          base_d  = '0;
        end
      end

      S_ISSUE: begin
        iss_d[0]    = 1'b1;
        first_d[0]  = (i_q == '0);
        pixel_addr  = layer_q ? 10'd0 : i_q;
        hid_raddr   = layer_q ? i_q[3:0] : 4'd0;
        weight_addr = base_q + 13'(i_q);
        if (last_term) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          i_d = i_q + 10'd1;
        end
      end

      // Products of the last few issued terms are still in flight.
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_WB;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end

      S_WB: begin
        if (!layer_q) begin
          hid_we    = 1'b1;
          hid_waddr = n_q;
          hid_wdata = relu(acc_in);
        end else if ((n_q == '0) || (acc_in > best_q)) begin
          // Strict compare: ties keep the earlier (lower) index.
          best_d     = acc_in;
          best_idx_d = n_q;
        end
        i_d = '0;
        if (!last_neur) begin
          state_d = S_ISSUE;
          n_d     = n_q + 4'd1;
          base_d  = base_q + (layer_q ? L2_STEP : L1_STEP);
        end else if (!layer_q) begin
          state_d = S_ISSUE;
          layer_d = 1'b1;
          n_d     = '0;
          base_d  = L2_BASE;
        end else begin
          state_d = S_DONE;
          layer_d = 1'b0;
          digit_d = best_idx_d;
        end
      end

      S_DONE: begin
        digit_valid = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Stage p1..pMEM_LAT: control registers and delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      layer_q    <= 1'b0;
      n_q        <= '0;
      i_q        <= '0;
      drain_q    <= '0;
      base_q     <= '0;
      iss_q      <= '0;
      first_q    <= '0;
      best_idx_q <= '0;
      digit_q    <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      n_q        <= n_d;
      i_q        <= i_d;
      drain_q    <= drain_d;
      base_q     <= base_d;
      iss_q      <= iss_d;
      first_q    <= first_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
    end
  end

  // Best score is data; it is always loaded at output neuron 0.
  always_ff @(posedge clk) begin
    best_q <= best_d;
  end

  assign busy      = (state_q != S_IDLE);
  assign layer     = layer_q;
  assign mac_en    = iss_q[MEM_LAT-1];
  assign mac_first = first_q[MEM_LAT-1];
  assign digit     = digit_q;

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Top-level scheduler for the time-multiplexed MNIST classifier datapath. On `start` it sequences one shared multiply-accumulate unit through layer 1 (784 pixels × 10 hidden neurons) and then layer 2 (10 hidden × 10 outputs). It generates pixel, weight and hidden-RAM addresses, aligns the MAC control strobes to the memory read latency, and writes hidden activations back. It tracks the argmax of the output layer and reports the classified digit with a done pulse.

## Interface
- `N_PIXELS`, 784, layer-1 input count
- `N_HIDDEN`, 10, hidden neuron count (layer-2 input count)
- `N_OUT`, 10, output neuron count
- `MEM_LAT`, 2, read latency in cycles from address to data, pixel/weight/hidden memories (≥1)
- `ACC_W`, 24, MAC accumulator width (signed)

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — synchronous, active-high reset
- `start` in 1 — request one inference; sampled only in IDLE
- `busy` out 1 — high from cycle after accepted `start` through DONE cycle
- `pixel_addr` out 10 — pixel ROM address
- `weight_addr` out 13 — unified weight ROM address; layer 1 at `n*N_PIXELS+i`, layer 2 at `N_PIXELS*N_HIDDEN + n*N_HIDDEN + k`
- `hid_raddr` out 4 — hidden RAM read address (layer 2)
- `layer` out 1 — 0 = layer 1 operands, 1 = layer 2 operands (MAC operand mux select)
- `mac_en` out 1 — product valid at MAC inputs this cycle
- `mac_first` out 1 — with `mac_en`: load product, do not accumulate
- `acc_in` in ACC_W — MAC registered accumulator output
- `hid_we` out 1 — hidden RAM write strobe
- `hid_waddr` out 4 — hidden RAM write address
- `hid_wdata` out ACC_W — hidden RAM write data
- `digit` out 4 — classified digit, held until next DONE
- `digit_valid` out 1 — one-cycle pulse with final `digit`

## Operation
- States: IDLE, ISSUE, DRAIN, WB, DONE. Counters: neuron `n`, term `i`, `drain`, and the `layer` bit.
- IDLE: all strobes low. `start`=1 → ISSUE; `layer`=0, `n`=0, `i`=0.
- ISSUE: drive addresses for term `i`, then increment `i`. At the last term (`i`=N_PIXELS-1 in layer 1, N_HIDDEN-1 in layer 2) → DRAIN, `drain`=0.
- ISSUE, layer 2: `pixel_addr` holds 0; `hid_raddr`=`i`.
- DRAIN: lasts exactly MEM_LAT cycles, then → WB.
- WB: one cycle, `acc_in` holds the neuron's final sum.
  - Layer 1: `hid_we`=1, `hid_waddr`=`n`.
  - Layer 2: argmax update.
  - Then: if `n` is not last, `n`+1, `i`=0 → ISSUE. If last neuron of layer 1, `layer`=1, `n`=0 → ISSUE. If last neuron of layer 2 → DONE.
- DONE: `digit_valid`=1 for one cycle, `digit` updated → IDLE.
- `mac_en`/`mac_first`: an "issued" flag (high in ISSUE) and "i==0" flag, delayed by a MEM_LAT-deep shift register. The last `mac_en` of a neuron lands on the final DRAIN cycle.
- Argmax: signed compare. At layer-2 `n`=0, load best=`acc_in`, idx=0. For later `n`, replace only if `acc_in` > best (strict). Ties keep the lower index.
- `start` while busy is ignored. There is no queuing.
- Address arithmetic uses a running base register (`base += N_PIXELS` or `N_HIDDEN` per neuron) plus `i`. No multiplier.

## Timing
- Reset: state IDLE; all outputs 0 (`digit`=0, `busy`=0, all strobes 0); delay line cleared. Reset mid-inference aborts with no `digit_valid` and no further `hid_we`.
- Cycles per neuron = N + MEM_LAT + 1, where N is the term count.
- Defaults: layer 1 = 10×787 = 7870 cycles; layer 2 = 10×13 = 130 cycles.
- `start` at cycle 0 (IDLE) → `busy` at cycle 1 → `digit_valid` at cycle 1+7870+130 = 8001. `busy` falls at cycle 8002. A new `start` is accepted at cycle 8002.
- First `mac_en` (with `mac_first`) occurs MEM_LAT cycles after the first ISSUE cycle.
- `mac_en` is never high in WB, DONE or IDLE.
- Layer-2 `hid_raddr` never reads a hidden entry in the same cycle as its `hid_we`. Layer 1 completes entirely before layer 2 starts.

## Configuration
- `SEQ_RELU_EN` defined: `hid_wdata` = 0 when `acc_in` is negative, else `acc_in` (ReLU on hidden activations).
- `SEQ_RELU_EN` undefined: `hid_wdata` = `acc_in` unchanged.
- Output-layer argmax never applies ReLU in either build.

## Test plan
- Reset then a single `start` → `busy` 1 at cycle 1; `digit_valid` exactly at cycle 8001; `busy` 0 at 8002. Exactly 10 `hid_we` pulses with `hid_waddr` 0..9. Exactly 7940 `mac_en` cycles, and 20 of them carry `mac_first`.
- Address check → neuron 3, term 5 of layer 1 issues `weight_addr`=2357, `pixel_addr`=5. Layer-2 neuron 9, term 9 issues `weight_addr`=7939, `hid_raddr`=9.
- Output sums model with scores {−5,3,7,7,−1,0,2,6,1,−9} → `digit`=2 (tie with 3 keeps lower). All-negative scores {−9..−1} with max at index 8 → `digit`=8.
- `acc_in`=−4 at a layer-1 WB → `hid_wdata`=0 with `SEQ_RELU_EN`, and −4 without it.
- `start` pulsed at cycle 500 and 7900 during an inference → ignored; single `digit_valid` at 8001.
- `rst` asserted at cycle 4000 → next cycle all outputs 0, state IDLE. No `digit_valid` occurs. A later `start` completes a full 8001-cycle inference correctly.
